// File: rtl/sp_bram.sv
// sp_bram: behavioural 16 Kbit single-port block RAM.
// One read/write port with configurable width (1..32 bits).
// Byte enables ride in the low address bits.
// An instance only responds when blksel_i matches BLK_SEL, so a wrapper can
// tile instances into rows.
// Storage is held as 64 lines of 256 bits. This lets the power-on contents be
// the INIT_VALUE pattern replicated, with word w at bits [w*BIT_WIDTH +: BIT_WIDTH].
module sp_bram #(
    parameter logic [1:0]   READ_MODE  = 2'b00,
    parameter logic [1:0]   WRITE_MODE = 2'b00,
    parameter int           BIT_WIDTH  = 32,
    parameter logic [2:0]   BLK_SEL    = 3'd0,
    parameter logic [255:0] INIT_VALUE = 256'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic        wre_i,
    input  logic        oce_i,
    input  logic [2:0]  blksel_i,
    input  logic [13:0] ad_i,
    input  logic [31:0] di_i,
    output logic [31:0] do_o
);

    // Byte lanes exist only for 16/32-bit ports; narrower ports write whole words
    localparam int NBYTES = (BIT_WIDTH >= 16) ? (BIT_WIDTH / 8) : 1;
    localparam int BYTE_W = (BIT_WIDTH >= 16) ? 8 : BIT_WIDTH;

    // Reject unsupported configurations at elaboration
    generate
        if (!(BIT_WIDTH == 1 || BIT_WIDTH == 2 || BIT_WIDTH == 4 ||
              BIT_WIDTH == 8 || BIT_WIDTH == 16 || BIT_WIDTH == 32)) begin : g_bad_width
            $fatal(1, "sp_bram: illegal BIT_WIDTH %0d", BIT_WIDTH);
        end
        if (READ_MODE > 2'd1) begin : g_bad_read_mode
            $fatal(1, "sp_bram: illegal READ_MODE %0d", READ_MODE);
        end
        if (WRITE_MODE > 2'd2) begin : g_bad_write_mode
            $fatal(1, "sp_bram: illegal WRITE_MODE %0d", WRITE_MODE);
        end
    endgenerate

    // 64 x 256-bit lines, loaded with the init pattern and never reset
    logic [255:0] mem_reg [64] = '{default: INIT_VALUE};

    logic                 acc;
    logic [13:0]          bit_addr;
    logic [BIT_WIDTH-1:0] old_word;
    logic [BIT_WIDTH-1:0] merged;
    logic [NBYTES-1:0]    be;
    logic [BIT_WIDTH-1:0] data_reg;
    logic [BIT_WIDTH-1:0] out_reg;

    assign acc = ce_i && (blksel_i == BLK_SEL);

    // The word address sits in the top bits of ad_i.
    // Clearing the low log2(BIT_WIDTH) bits gives the word's bit position in the
    // 16 Kbit array. The upper 6 bits select the line; the lower 8 bits give the
    // offset within that line.
    assign bit_addr = ad_i & ~(14'(BIT_WIDTH) - 14'd1);
    assign old_word = mem_reg[bit_addr[13:8]][bit_addr[7:0] +: BIT_WIDTH];

    // Byte-enable decode from the address bits below the word address
    generate
        if (BIT_WIDTH == 32) begin : g_be32
            assign be = ad_i[3:0];
        end else if (BIT_WIDTH == 16) begin : g_be16
            assign be = ad_i[1:0];
        end else begin : g_be_word
            assign be = '1;
        end
    endgenerate

    // Enabled lanes take new data; the others keep the stored value
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
            assign merged[gi*BYTE_W +: BYTE_W] = be[gi] ? di_i[gi*BYTE_W +: BYTE_W]
                                                        : old_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Array write: only the addressed word changes
    always_ff @(posedge clk_i) begin
        if (acc && wre_i) begin
            mem_reg[bit_addr[13:8]][bit_addr[7:0] +: BIT_WIDTH] <= merged;
        end
    end

    // Data register: reads load the stored word; writes follow WRITE_MODE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_reg <= '0;
        end else if (acc) begin
            if (!wre_i) begin
                data_reg <= old_word;
            end else if (WRITE_MODE == 2'd1) begin
                data_reg <= merged;
            end else if (WRITE_MODE == 2'd2) begin
                data_reg <= old_word;
            end
        end
    end

    // Output register stage, only advanced in pipeline mode when oce_i is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_reg <= '0;
        end else if ((READ_MODE == 2'd1) && oce_i) begin
            out_reg <= data_reg;
        end
    end

    assign do_o = 32'((READ_MODE == 2'd1) ? out_reg : data_reg);

    // Bits that are don't-care for some configurations
    logic unused_bits;
    assign unused_bits = ^{ad_i, di_i, oce_i, out_reg};

endmodule

// File: tb/tb_sp_bram.sv
// Directed self-checking bench for sp_bram.
// Six instances cover these configurations:
//   a: 32-bit bypass
//   b: block select 2
//   c: 8-bit width with all-ones init
//   d: write-through
//   e: read-before-write
//   f: pipeline
module tb_sp_bram;

    logic        clk;
    logic        rst_n;
    logic [5:0]  ce;
    logic        wre;
    logic        oce;
    logic [2:0]  blksel;
    logic [13:0] ad;
    logic [31:0] di;
    logic [31:0] do_a, do_b, do_c, do_d, do_e, do_f;

    int checks = 0;
    int errors = 0;

    sp_bram #(.READ_MODE(2'b00), .WRITE_MODE(2'b00), .BIT_WIDTH(32), .BLK_SEL(3'd0), .INIT_VALUE(256'h0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce[0]), .wre_i(wre), .oce_i(oce),
        .blksel_i(blksel), .ad_i(ad), .di_i(di), .do_o(do_a));

    sp_bram #(.READ_MODE(2'b00), .WRITE_MODE(2'b00), .BIT_WIDTH(32), .BLK_SEL(3'd2), .INIT_VALUE(256'h0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce[1]), .wre_i(wre), .oce_i(oce),
        .blksel_i(blksel), .ad_i(ad), .di_i(di), .do_o(do_b));

    sp_bram #(.READ_MODE(2'b00), .WRITE_MODE(2'b00), .BIT_WIDTH(8), .BLK_SEL(3'd0), .INIT_VALUE({256{1'b1}})) u_c (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce[2]), .wre_i(wre), .oce_i(oce),
        .blksel_i(blksel), .ad_i(ad), .di_i(di), .do_o(do_c));

    sp_bram #(.READ_MODE(2'b00), .WRITE_MODE(2'b01), .BIT_WIDTH(32), .BLK_SEL(3'd0), .INIT_VALUE(256'h0)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce[3]), .wre_i(wre), .oce_i(oce),
        .blksel_i(blksel), .ad_i(ad), .di_i(di), .do_o(do_d));

    sp_bram #(.READ_MODE(2'b00), .WRITE_MODE(2'b10), .BIT_WIDTH(32), .BLK_SEL(3'd0), .INIT_VALUE(256'h0)) u_e (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce[4]), .wre_i(wre), .oce_i(oce),
        .blksel_i(blksel), .ad_i(ad), .di_i(di), .do_o(do_e));

    sp_bram #(.READ_MODE(2'b01), .WRITE_MODE(2'b00), .BIT_WIDTH(32), .BLK_SEL(3'd0), .INIT_VALUE(256'h0)) u_f (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce[5]), .wre_i(wre), .oce_i(oce),
        .blksel_i(blksel), .ad_i(ad), .di_i(di), .do_o(do_f));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One access: inputs applied on a falling edge, taken at the next rising
    // edge, and released on the following falling edge (where do_o is checked).
    task automatic access(input int k, input logic we, input logic [2:0] bs,
                          input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        ce     = 6'b0;
        ce[k]  = 1'b1;
        wre    = we;
        blksel = bs;
        ad     = a;
        di     = d;
        @(negedge clk);
        ce  = 6'b0;
        wre = 1'b0;
        $display("access inst=%0d we=%0b blksel=%0d ad=%0d di=%h", k, we, bs, a, d);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ce     = 6'b0;
        wre    = 1'b0;
        oce    = 1'b1;
        blksel = 3'd0;
        ad     = 14'd0;
        di     = 32'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", do_a, 32'h0);
        check("reset_c", do_c, 32'h0);
        check("reset_f", do_f, 32'h0);
        rst_n = 1'b1;

        // 32-bit bypass, normal write mode
        access(0, 1'b1, 3'd0, 14'd175, 32'hDEADBEEF);   // word 5, all bytes
        check("a_write_holds", do_a, 32'h0);
        access(0, 1'b0, 3'd0, 14'd160, 32'h0);
        check("a_read_w5", do_a, 32'hDEADBEEF);
        access(0, 1'b1, 3'd0, 14'd165, 32'h11223344);   // word 5, bytes 0 and 2
        check("a_be_write_holds", do_a, 32'hDEADBEEF);
        access(0, 1'b0, 3'd0, 14'd160, 32'h0);
        check("a_be_read_w5", do_a, 32'hDE22BE44);
        access(0, 1'b0, 3'd0, 14'd192, 32'h0);
        check("a_read_w6_init", do_a, 32'h0);

        // Block select = 2
        access(1, 1'b1, 3'd2, 14'd111, 32'h12345678);   // word 3
        access(1, 1'b0, 3'd2, 14'd96, 32'h0);
        check("b_read_w3", do_b, 32'h12345678);
        access(1, 1'b1, 3'd1, 14'd15, 32'h000000AA);    // wrong block: ignored
        check("b_ignored_write", do_b, 32'h12345678);
        access(1, 1'b0, 3'd1, 14'd0, 32'h0);            // wrong block: ignored
        check("b_ignored_read", do_b, 32'h12345678);
        access(1, 1'b0, 3'd2, 14'd0, 32'h0);
        check("b_read_w0_init", do_b, 32'h0);

        // 8-bit width, all-ones init
        access(2, 1'b0, 3'd0, 14'd8000, 32'h0);         // word 1000
        check("c_fresh_w1000", do_c, 32'h000000FF);
        access(2, 1'b1, 3'd0, 14'd8000, 32'h123456A5);
        check("c_write_holds", do_c, 32'h000000FF);
        access(2, 1'b0, 3'd0, 14'd8007, 32'h0);         // low bits ignored
        check("c_read_w1000", do_c, 32'h000000A5);
        access(2, 1'b0, 3'd0, 14'd8008, 32'h0);         // word 1001
        check("c_fresh_w1001", do_c, 32'h000000FF);

        // Write-through
        access(3, 1'b1, 3'd0, 14'd79, 32'h5);
        check("d_wt_5", do_d, 32'h5);
        access(3, 1'b1, 3'd0, 14'd79, 32'h7);
        check("d_wt_7", do_d, 32'h7);
        access(3, 1'b0, 3'd0, 14'd64, 32'h0);
        check("d_read_7", do_d, 32'h7);
        access(3, 1'b1, 3'd0, 14'd65, 32'hAABBCCDD);    // byte 0 only
        check("d_wt_merged", do_d, 32'h000000DD);

        // Read-before-write
        access(4, 1'b1, 3'd0, 14'd79, 32'h5);
        check("e_rbw_init", do_e, 32'h0);
        access(4, 1'b1, 3'd0, 14'd79, 32'h7);
        check("e_rbw_old5", do_e, 32'h5);
        access(4, 1'b0, 3'd0, 14'd64, 32'h0);
        check("e_read_7", do_e, 32'h7);

        // Pipeline read mode
        access(5, 1'b1, 3'd0, 14'd239, 32'h9ABCDEF0);   // word 7
        check("f_write_holds", do_f, 32'h0);
        access(5, 1'b0, 3'd0, 14'd224, 32'h0);
        check("f_lat1", do_f, 32'h0);
        @(negedge clk);
        check("f_lat2", do_f, 32'h9ABCDEF0);
        oce = 1'b0;
        access(5, 1'b0, 3'd0, 14'd256, 32'h0);          // word 8 = 0
        repeat (2) @(negedge clk);
        check("f_oce_hold", do_f, 32'h9ABCDEF0);
        oce = 1'b1;
        @(negedge clk);
        check("f_oce_load", do_f, 32'h0);
        access(5, 1'b0, 3'd0, 14'd224, 32'h0);
        @(negedge clk);
        check("f_before_rst", do_f, 32'h9ABCDEF0);
        #2 rst_n = 1'b0;
        #1;
        check("f_async_rst", do_f, 32'h0);
        check("d_async_rst", do_d, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access(5, 1'b0, 3'd0, 14'd224, 32'h0);
        @(negedge clk);
        check("f_after_rst", do_f, 32'h9ABCDEF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
